// File: rtl/writeback_unit_if.sv
// Purpose : bundles the write-back stage handshake, memory response and register-file write buses.
// Latency : n/a (wiring only).
// Backpressure: wb_ready from the stage throttles wb_valid; memory response has no backpressure.
// Ports (master = upstream pipeline + data memory, slave = writeback_unit):
//   wb_valid/wb_ready handshake, wb_sel/reg_write/rd_addr/funct3/alu_result/pc_plus4/imm operands,
//   mem_rvalid/mem_rdata load response, rf_we/rf_waddr/rf_wdata register write, wb_stall, bus_err.
interface writeback_unit_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [1:0]  wb_sel;
  logic        reg_write;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic [31:0] imm;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_stall;
  logic        bus_err;

  modport master (
    output wb_valid, wb_sel, reg_write, rd_addr, funct3, alu_result, pc_plus4, imm,
    output mem_rvalid, mem_rdata,
    input  wb_ready, rf_we, rf_waddr, rf_wdata, wb_stall, bus_err
  );

  modport slave (
    input  wb_valid, wb_sel, reg_write, rd_addr, funct3, alu_result, pc_plus4, imm,
    input  mem_rvalid, mem_rdata,
    output wb_ready, rf_we, rf_waddr, rf_wdata, wb_stall, bus_err
  );
endinterface

// File: rtl/writeback_unit.sv
// Purpose : write-back stage; selects ALU/load/PC+4/IMM result and writes the register file.
// Latency : non-load 1 cycle accept->rf_we; load 1 cycle after mem_rvalid; timeout after MEM_TIMEOUT wait cycles.
// Backpressure: wb_ready low (wb_stall high) while a load waits for memory; upstream holds.
// Ports: clk, rst_n (async active-low) plain; all other signals via writeback_unit_if.slave wb.
module writeback_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  writeback_unit_if.slave   wb
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  // Abort fires on the edge where the wait counter would reach MEM_TIMEOUT,
  // so the stage spends exactly MEM_TIMEOUT cycles in WAIT_MEM.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [4:0]  ld_rd_q;
  logic        ld_we_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_off_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic        bus_err_q;

  logic [31:0] nonload_wdata_d;
  logic [31:0] load_wdata_d;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'h000000, b};
      3'b101:  load_extend = {16'h0000, h};
      default: load_extend = w;  // LW and the undefined encodings
    endcase
  endfunction

  always_comb begin
    nonload_wdata_d = wb.alu_result;
    case (wb.wb_sel)
      2'b10:   nonload_wdata_d = wb.pc_plus4;
      2'b11:   nonload_wdata_d = wb.imm;
      default: nonload_wdata_d = wb.alu_result;
    endcase
  end

  assign load_wdata_d = load_extend(ld_f3_q, ld_off_q, wb.mem_rdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      ld_rd_q    <= 5'd0;
      ld_we_q    <= 1'b0;
      ld_f3_q    <= 3'd0;
      ld_off_q   <= 2'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      bus_err_q  <= 1'b0;
    end else begin
      rf_we_q   <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // wb_ready is high throughout IDLE, so wb_valid alone means accept.
          if (wb.wb_valid) begin
            if (wb.wb_sel == 2'b01) begin
              ld_rd_q  <= wb.rd_addr;
              ld_we_q  <= wb.reg_write;
              ld_f3_q  <= wb.funct3;
              ld_off_q <= wb.alu_result[1:0];
              cnt_q    <= 8'd0;
              state_q  <= WAIT_MEM;
            end else if (wb.reg_write && (wb.rd_addr != 5'd0)) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= wb.rd_addr;
              rf_wdata_q <= nonload_wdata_d;
            end
          end
        end
        WAIT_MEM: begin
          // rvalid is checked first so a response on the timeout cycle still completes.
          if (wb.mem_rvalid) begin
            state_q <= IDLE;
            if (ld_we_q && (ld_rd_q != 5'd0)) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= ld_rd_q;
              rf_wdata_q <= load_wdata_d;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            bus_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.wb_ready = (state_q == IDLE);
  assign wb.wb_stall = (state_q == WAIT_MEM);
  assign wb.rf_we    = rf_we_q;
  assign wb.rf_waddr = rf_waddr_q;
  assign wb.rf_wdata = rf_wdata_q;
  assign wb.bus_err  = bus_err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Purpose : self-checking bench for writeback_unit with directed and random transactions.
// Latency : n/a.
// Backpressure: bench honours wb_ready/wb_stall by only issuing from IDLE.
module tb_writeback_unit;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  writeback_unit_if bus ();

  writeback_unit #(.MEM_TIMEOUT(T)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference architectural view of the register-file write port.
  logic [4:0]  exp_waddr = 5'd0;
  logic [31:0] exp_wdata = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic we, input logic berr, input logic stall);
    chk({tag, "/rf_we"},    {31'd0, bus.rf_we},    {31'd0, we});
    chk({tag, "/rf_waddr"}, {27'd0, bus.rf_waddr}, {27'd0, exp_waddr});
    chk({tag, "/rf_wdata"}, bus.rf_wdata,          exp_wdata);
    chk({tag, "/bus_err"},  {31'd0, bus.bus_err},  {31'd0, berr});
    chk({tag, "/wb_stall"}, {31'd0, bus.wb_stall}, {31'd0, stall});
    chk({tag, "/wb_ready"}, {31'd0, bus.wb_ready}, {31'd0, !stall});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load result from the architectural rules: pick the lane, then extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    int b;
    int h;
    b = int'((w >> (8 * off)) & 32'hFF);
    h = int'((w >> (16 * (off / 2))) & 32'hFFFF);
    case (f3)
      3'd0:    return 32'((b >= 128) ? b - 256 : b);
      3'd1:    return 32'((h >= 32768) ? h - 65536 : h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic nonload(input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] im);
    logic [31:0] v;
    logic w;
    bus.wb_valid   = 1'b1;
    bus.wb_sel     = sel;
    bus.reg_write  = rw;
    bus.rd_addr    = rd;
    bus.funct3     = 3'($urandom);
    bus.alu_result = alu;
    bus.pc_plus4   = pc4;
    bus.imm        = im;
    tick();
    v = (sel == 2'b00) ? alu : (sel == 2'b10) ? pc4 : im;
    w = rw && (rd != 5'd0);
    if (w) begin
      exp_waddr = rd;
      exp_wdata = v;
    end
    check_outs("nonload", w, 1'b0, 1'b0);
  endtask

  // delay: wait cycle in which rvalid is presented; delay > T means no response.
  task automatic load(input logic rw, input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                      input logic [31:0] rdata, input int delay, input logic late);
    logic [31:0] addr;
    logic w;
    logic timed;
    int k;
    addr = $urandom;
    addr[1:0] = off;
    bus.wb_valid   = 1'b1;
    bus.wb_sel     = 2'b01;
    bus.reg_write  = rw;
    bus.rd_addr    = rd;
    bus.funct3     = f3;
    bus.alu_result = addr;
    bus.pc_plus4   = $urandom;
    bus.imm        = $urandom;
    tick();
    // A competing instruction held on the bus must not be accepted while waiting.
    bus.wb_sel     = 2'b00;
    bus.reg_write  = 1'b1;
    bus.rd_addr    = 5'd7;
    bus.alu_result = $urandom;
    timed = 1'b0;
    k = 1;
    while (1) begin
      check_outs("load_wait", 1'b0, 1'b0, 1'b1);
      bus.mem_rvalid = (k == delay);
      bus.mem_rdata  = (k == delay) ? rdata : $urandom;
      tick();
      if (k == delay) break;
      if (k >= T) begin
        timed = 1'b1;
        break;
      end
      k++;
    end
    bus.mem_rvalid = 1'b0;
    bus.wb_valid   = 1'b0;
    w = !timed && rw && (rd != 5'd0);
    if (w) begin
      exp_waddr = rd;
      exp_wdata = ref_load(f3, int'(off), rdata);
    end
    check_outs(timed ? "load_timeout" : "load_done", w, timed, 1'b0);
    if (timed && late) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      tick();
      bus.mem_rvalid = 1'b0;
      check_outs("late_rvalid", 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [1:0] sel;
    logic [4:0] rd;
    bus.wb_valid   = 1'b0;
    bus.wb_sel     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.rd_addr    = 5'd0;
    bus.funct3     = 3'd0;
    bus.alu_result = 32'd0;
    bus.pc_plus4   = 32'd0;
    bus.imm        = 32'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;

    repeat (2) tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    nonload(2'b00, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0);
    chk("alu_wdata", bus.rf_wdata, 32'h0000_1234);
    nonload(2'b10, 1'b1, 5'd0, 32'h0, 32'h0000_0104, 32'h0);
    load(1'b1, 5'd3, 3'b000, 2'd3, 32'h80FF_0000, 3, 1'b0);
    chk("lb_wdata", bus.rf_wdata, 32'hFFFF_FF80);
    load(1'b1, 5'd4, 3'b101, 2'd2, 32'h80FF_0000, 2, 1'b0);
    chk("lhu_wdata", bus.rf_wdata, 32'h0000_80FF);
    load(1'b1, 5'd6, 3'b010, 2'd0, 32'hDEAD_BEEF, T + 3, 1'b1);
    load(1'b1, 5'd8, 3'b001, 2'd1, 32'h1234_F678, T, 1'b0);
    load(1'b1, 5'd9, 3'b110, 2'd3, 32'hCAFE_F00D, 1, 1'b0);
    nonload(2'b11, 1'b1, 5'd10, 32'h0, 32'h0, 32'hABCD_0000);
    nonload(2'b00, 1'b0, 5'd11, 32'h5555_5555, 32'h0, 32'h0);
    nonload(2'b10, 1'b1, 5'd31, 32'h0, 32'h0000_2000, 32'h0);
    bus.wb_valid = 1'b0;
    tick();

    // Reset while a load is outstanding: back to IDLE at once, nothing written.
    bus.wb_valid  = 1'b1;
    bus.wb_sel    = 2'b01;
    bus.reg_write = 1'b1;
    bus.rd_addr   = 5'd12;
    bus.funct3    = 3'b010;
    tick();
    bus.wb_valid = 1'b0;
    tick();
    check_outs("pre_reset_wait", 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    exp_waddr = 5'd0;
    exp_wdata = 32'd0;
    check_outs("async_reset", 1'b0, 1'b0, 1'b0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    tick();
    rst_n = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    check_outs("post_reset", 1'b0, 1'b0, 1'b0);

    // Random mix of loads and non-loads.
    for (int i = 0; i < 300; i++) begin
      sel = 2'($urandom_range(0, 3));
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      if (sel == 2'b01)
        load($urandom_range(0, 4) != 0, rd, 3'($urandom), 2'($urandom), $urandom,
             $urandom_range(1, T + 2), 1'($urandom));
      else
        nonload(sel, $urandom_range(0, 4) != 0, rd, $urandom, $urandom, $urandom);
    end
    bus.wb_valid = 1'b0;
    tick();
    check_outs("final_idle", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
